vectrex_cart_loader: RTL and testbench



---
 rtl/vectrex_cart_loader.sv | 197 +++++++++++++++++++
 tb/tb_vectrex_cart_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vectrex_cart_loader.sv
// ============================================================================
// Module   : vectrex_cart_loader
// Brief    : Turns the ioctl download stream into cartridge-memory writes,
//            tracks the image address mask and sequences the core reset
//            (including the optional skip-logo pulse).
//            Optional checksum accumulator: define CART_LOADER_CKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vectrex_cart_loader #(
    parameter int ADDR_W     = 15,
    parameter int SKIP_DELAY = 5000000,
    parameter int SKIP_PULSE = 1000
) (
    input  logic              clk_sys_i,
    input  logic              reset_n_i,
    input  logic              ioctl_download_i,
    input  logic              ioctl_wr_i,
    input  logic [24:0]       ioctl_addr_i,
    input  logic [7:0]        ioctl_dout_i,
    input  logic              skip_logo_i,
    output logic              cart_wr_o,
    output logic [ADDR_W-1:0] cart_addr_o,
    output logic [7:0]        cart_data_o,
    output logic [ADDR_W-1:0] cart_mask_o,
    output logic              core_reset_o,
    output logic              loaded_o,
    output logic              overflow_o,
    output logic [15:0]       cksum_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PULSE = 2'd3
    } state_t;

    localparam logic [22:0] c_WAIT_CNT  = 23'(SKIP_DELAY - SKIP_PULSE - 1);
    localparam logic [22:0] c_PULSE_CNT = 23'(SKIP_PULSE - 1);

    state_t              state_q;
    logic [22:0]         cnt_q;
    logic                old_dl_q;
    logic                armed_q;
    logic                cart_wr_q;
    logic [ADDR_W-1:0]   cart_addr_q;
    logic [7:0]          cart_data_q;
    logic [ADDR_W-1:0]   cart_mask_q;
    logic [ADDR_W-1:0]   cart_mask_d;
    logic                overflow_q;
    logic                overflow_d;
    logic                core_reset_q;
    logic                loaded_q;

    logic                w_rise;
    logic                w_fall;
    logic                w_strobe;
    logic                w_in_range;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_mask_base;

    // armed_q blocks edge detection until the download has been seen low,
    // so a download still active when reset releases is not re-detected.
    assign w_rise      = ioctl_download_i & ~old_dl_q & armed_q;
    assign w_fall      = ~ioctl_download_i & old_dl_q;
    assign w_strobe    = ioctl_download_i & ioctl_wr_i;
    assign w_in_range  = (ioctl_addr_i[24:ADDR_W] == '0);
    assign w_accept    = w_strobe & w_in_range;
    assign w_mask_base = w_rise ? '0 : cart_mask_q;

    always_comb begin
        cart_mask_d = w_mask_base;
        if (w_accept && ((ioctl_addr_i[ADDR_W-1:0] & ~w_mask_base) != '0)) begin
            cart_mask_d = {w_mask_base[ADDR_W-2:0], 1'b1};
        end
        overflow_d = w_rise ? 1'b0 : overflow_q;
        if (w_strobe && !w_in_range) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            old_dl_q    <= 1'b0;
            armed_q     <= 1'b0;
            cart_wr_q   <= 1'b0;
            cart_addr_q <= '0;
            cart_data_q <= '0;
            cart_mask_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            old_dl_q    <= ioctl_download_i;
            armed_q     <= armed_q | ~ioctl_download_i;
            cart_wr_q   <= w_accept;
            cart_mask_q <= cart_mask_d;
            overflow_q  <= overflow_d;
            if (w_accept) begin
                cart_addr_q <= ioctl_addr_i[ADDR_W-1:0];
                cart_data_q <= ioctl_dout_i;
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            core_reset_q <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (w_rise) begin
                        state_q      <= ST_LOAD;
                        core_reset_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_fall) begin
                        loaded_q     <= 1'b1;
                        core_reset_q <= 1'b0;
                        if (skip_logo_i) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= c_WAIT_CNT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_rise) begin
                        state_q      <= ST_LOAD;
                        core_reset_q <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q      <= ST_PULSE;
                        cnt_q        <= c_PULSE_CNT;
                        core_reset_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 23'd1;
                    end
                end
                ST_PULSE: begin
                    if (w_rise) begin
                        state_q      <= ST_LOAD;
                        core_reset_q <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q      <= ST_IDLE;
                        core_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 23'd1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    core_reset_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CART_LOADER_CKSUM_EN
    logic [15:0] cksum_q;
    logic [15:0] cksum_d;

    always_comb begin
        cksum_d = w_rise ? 16'h0000 : cksum_q;
        if (w_accept) begin
            cksum_d = cksum_d + {8'h00, ioctl_dout_i};
        end
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cksum_q <= 16'h0000;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum_o = cksum_q;
`else
    assign cksum_o = 16'h0000;
`endif

    assign cart_wr_o    = cart_wr_q;
    assign cart_addr_o  = cart_addr_q;
    assign cart_data_o  = cart_data_q;
    assign cart_mask_o  = cart_mask_q;
    assign core_reset_o = core_reset_q;
    assign loaded_o     = loaded_q;
    assign overflow_o   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vectrex_cart_loader.sv
// ============================================================================
// Module   : tb_vectrex_cart_loader
// Brief    : Self-checking bench for vectrex_cart_loader (write scoreboard,
//            vector table and reset-sequence checks).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vectrex_cart_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        skip_logo;
    logic        cart_wr;
    logic [14:0] cart_addr;
    logic [7:0]  cart_data;
    logic [14:0] cart_mask;
    logic        core_reset;
    logic        loaded;
    logic        overflow;
    logic [15:0] cksum;

    int n_cmp = 0;
    int n_bad = 0;

    logic [22:0] wr_q[$];

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_wr;
        logic [14:0] exp_mask;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    vectrex_cart_loader #(
        .ADDR_W     (15),
        .SKIP_DELAY (20),
        .SKIP_PULSE (5)
    ) dut (
        .clk_sys_i        (clk),
        .reset_n_i        (reset_n),
        .ioctl_download_i (ioctl_download),
        .ioctl_wr_i       (ioctl_wr),
        .ioctl_addr_i     (ioctl_addr),
        .ioctl_dout_i     (ioctl_dout),
        .skip_logo_i      (skip_logo),
        .cart_wr_o        (cart_wr),
        .cart_addr_o      (cart_addr),
        .cart_data_o      (cart_data),
        .cart_mask_o      (cart_mask),
        .core_reset_o     (core_reset),
        .loaded_o         (loaded),
        .overflow_o       (overflow),
        .cksum_o          (cksum)
    );

    // Write monitor: every strobe driven before an edge must show up right after it.
    always @(posedge clk) begin
        #1;
        n_cmp++;
        if (wr_q.size() != 0) begin
            logic [22:0] exp;
            exp = wr_q.pop_front();
            if (!cart_wr || {cart_addr, cart_data} !== exp) begin
                n_bad++;
                $display("FAIL cart_write: got wr=%b addr=%h data=%h, expected wr=1 addr=%h data=%h",
                         cart_wr, cart_addr, cart_data, exp[22:8], exp[7:0]);
            end
        end else if (cart_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL cart_write_spurious: got wr=%b addr=%h, expected wr=0", cart_wr, cart_addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input logic acc);
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = a;
        ioctl_dout     = d;
        if (acc) wr_q.push_back({a[14:0], d});
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic dl_start();
        ioctl_download = 1'b1;
        @(negedge clk);
        check("core_reset_rise", 32'(core_reset), 32'd1);
    endtask

    task automatic dl_end(input logic skip);
        ioctl_wr       = 1'b0;
        skip_logo      = skip;
        ioctl_download = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [24:0] a;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        skip_logo      = 1'b0;

        vecs[0] = '{25'h0000000, 8'h11, 1'b1, 15'h0000, 1'b0};
        vecs[1] = '{25'h0000001, 8'h22, 1'b1, 15'h0001, 1'b0};
        vecs[2] = '{25'h0000005, 8'h33, 1'b1, 15'h0003, 1'b0};
        vecs[3] = '{25'h0000004, 8'h44, 1'b1, 15'h0007, 1'b0};
        vecs[4] = '{25'h0000100, 8'h55, 1'b1, 15'h000F, 1'b0};
        vecs[5] = '{25'h0008000, 8'h66, 1'b0, 15'h000F, 1'b1};
        vecs[6] = '{25'h0007FFF, 8'h77, 1'b1, 15'h001F, 1'b1};
        vecs[7] = '{25'h1FFFFFF, 8'h88, 1'b0, 15'h001F, 1'b1};

        cyc(3);
        check("reset_wr",    32'(cart_wr),    32'd0);
        check("reset_mask",  32'(cart_mask),  32'd0);
        check("reset_core",  32'(core_reset), 32'd0);
        check("reset_load",  32'(loaded),     32'd0);
        check("reset_ovf",   32'(overflow),   32'd0);
        check("reset_cksum", 32'(cksum),      32'd0);
        reset_n = 1'b1;
        cyc(2);

        // Basic 4 KB load
        dl_start();
        for (int i = 0; i < 4096; i++) begin
            strobe(25'(i), 8'(i) ^ 8'h5A, 1'b1);
            if (i % 1024 == 512) check("core_reset_during_dl", 32'(core_reset), 32'd1);
        end
        dl_end(1'b0);
        check("core_reset_fall", 32'(core_reset), 32'd0);
        check("mask_4k",   32'(cart_mask), 32'h0FFF);
        check("loaded_4k", 32'(loaded),    32'd1);
        cyc(3);
        check("core_reset_idle", 32'(core_reset), 32'd0);

        // Odd size, back-to-back strobes
        dl_start();
        check("mask_cleared", 32'(cart_mask), 32'd0);
        for (int i = 0; i < 3000; i++) strobe(25'(i), 8'(i * 7), 1'b1);
        dl_end(1'b0);
        check("mask_3000", 32'(cart_mask), 32'h0FFF);
        check("ovf_3000",  32'(overflow),  32'd0);
        cyc(2);

        // Vector table: mask growth and out-of-range drops
        dl_start();
        for (int i = 0; i < 8; i++) begin
            strobe(vecs[i].addr, vecs[i].data, vecs[i].exp_wr);
            check($sformatf("vec%0d_mask", i), 32'(cart_mask), 32'(vecs[i].exp_mask));
            check($sformatf("vec%0d_ovf", i),  32'(overflow),  32'(vecs[i].exp_ovf));
        end
        dl_end(1'b0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        cyc(2);
        dl_start();
        check("ovf_cleared", 32'(overflow), 32'd0);
        strobe(25'h3, 8'h01, 1'b1);
        dl_end(1'b0);
        cyc(2);

        // Skip-logo sequence: 15 cycles low then 5 high; late skip_logo change ignored
        dl_start();
        strobe(25'h10, 8'hAB, 1'b1);
        ioctl_wr       = 1'b0;
        skip_logo      = 1'b1;
        ioctl_download = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            skip_logo = 1'b0;
            check($sformatf("skip_seq_%0d", k), 32'(core_reset), (k >= 15 && k < 20) ? 32'd1 : 32'd0);
        end

        // New download during WAIT abandons the pulse
        dl_start();
        dl_end(1'b1);
        cyc(5);
        check("wait_low", 32'(core_reset), 32'd0);
        dl_start();
        dl_end(1'b0);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check($sformatf("no_pulse_%0d", k), 32'(core_reset), 32'd0);
        end

        // Asynchronous reset mid-download
        dl_start();
        for (int i = 0; i < 100; i++) strobe(25'(i), 8'(i), 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_wr",    32'(cart_wr),    32'd0);
        check("arst_addr",  32'(cart_addr),  32'd0);
        check("arst_data",  32'(cart_data),  32'd0);
        check("arst_mask",  32'(cart_mask),  32'd0);
        check("arst_core",  32'(core_reset), 32'd0);
        check("arst_load",  32'(loaded),     32'd0);
        check("arst_ovf",   32'(overflow),   32'd0);
        check("arst_cksum", 32'(cksum),      32'd0);
        cyc(2);
        reset_n = 1'b1;
        for (int i = 100; i < 200; i++) begin
            strobe(25'(i), 8'(i), 1'b1);
            if (i % 25 == 0) check("arst_no_load", 32'(core_reset), 32'd0);
        end
        check("arst_mask_after", 32'(cart_mask), 32'h00FF);
        dl_end(1'b0);
        check("arst_core_after",   32'(core_reset), 32'd0);
        check("arst_loaded_after", 32'(loaded),     32'd0);
        dl_start();
        dl_end(1'b0);
        check("reedge_loaded", 32'(loaded), 32'd1);
        cyc(2);

        // Checksum over 257 bytes of FF
        dl_start();
        check("cksum_cleared", 32'(cksum), 32'd0);
        for (int i = 0; i < 257; i++) strobe(25'(i), 8'hFF, 1'b1);
        dl_end(1'b0);
        check("mask_257", 32'(cart_mask), 32'h01FF);
`ifdef CART_LOADER_CKSUM_EN
        check("cksum_257", 32'(cksum), 32'h0000FFFF);
`else
        check("cksum_257", 32'(cksum), 32'h00000000);
`endif
        cyc(3);
        a = 25'(wr_q.size());
        check("scoreboard_drained", 32'(a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
